pht_port_arbiter: RTL
=====================

Name: pht_port_arbiter

Overview:
- Owns the single-ported pattern history table (PHT) of 2-bit saturating counters used by the branch predictor.
- Shares the PHT port between two requesters:
  - IF-stage prediction lookups, which have priority.
  - ID-stage resolved-branch updates, buffered in a small queue and applied as read-modify-write.
- After reset, sequences a full-table initialisation to weakly-not-taken before accepting any traffic.

Parameters:
IDX_W, 10, PHT index width; table depth 2**IDX_W
CTR_W, 2, counter width
QDEPTH, 4, update queue depth (power of 2, >=2)
AGE_LIMIT, 8, max cycles a queue head may wait (optional feature only)

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous, active-low reset
lookup_req  in  1  IF requests prediction
lookup_idx  in  IDX_W  IF index (PC[IDX_W+1:2])
lookup_grant  out  1  lookup accepted this cycle (comb)
lookup_valid  out  1  result valid (one cycle after grant)
lookup_taken  out  1  predicted taken (counter MSB)
upd_valid  in  1  ID presents resolved branch
upd_idx  in  IDX_W  index of resolved branch
upd_taken  in  1  actual outcome
upd_ready  out  1  queue can accept (comb from registered count)
busy  out  1  initialisation in progress
pht_en  out  1  PHT port enable
pht_we  out  1  PHT write enable
pht_addr  out  IDX_W  PHT address
pht_wdata  out  CTR_W  PHT write data
pht_rdata  in  CTR_W  PHT read data (synchronous, valid cycle after read)

Behaviour:
- FSM states: INIT, IDLE, UPD_WR.
- RESET low, at any time including mid-operation:
  - state=INIT, init_ptr=0, queue emptied (head=tail=count=0).
  - lookup_valid=0.
  - Any in-flight update is discarded.
- INIT:
  - Each cycle drive pht_en=1, pht_we=1, pht_addr=init_ptr, pht_wdata=01 (weakly not taken); init_ptr increments.
  - After writing index 2**IDX_W-1, go to IDLE.
  - busy=1; lookup_grant=0; upd_ready=0.
  - Total duration is 2**IDX_W cycles.
- Outputs in IDLE/UPD_WR: busy=0; upd_ready = (count != QDEPTH).
- Enqueue: upd_valid && upd_ready pushes {upd_idx, upd_taken} at tail.
  - A pop in the same cycle does not make a full queue accept.
- drain_now = (count != 0) && (!lookup_req || count == QDEPTH || age_trip).
  - age_trip=0 unless the optional feature is enabled.
- IDLE:
  - If drain_now: read the queue head (pht_en=1, pht_we=0, pht_addr=head idx), lookup_grant=0, go to UPD_WR.
  - Else if lookup_req: lookup_grant=1, read lookup_idx.
  - Else pht_en=0.
- UPD_WR:
  - lookup_grant=0.
  - new = saturating update of pht_rdata:
    - taken: +1, saturating at 2**CTR_W-1;
    - not taken: -1, saturating at 0.
  - Drive pht_en=1, pht_we=1, pht_addr=head idx, pht_wdata=new.
  - Pop the head; return to IDLE.
- Port occupancy: an update uses two port cycles; lookups are denied in both.
- lookup_valid is registered lookup_grant; lookup_taken = pht_rdata[CTR_W-1] when lookup_valid, else 0.
- Queue pointers wrap modulo QDEPTH.
- Ordering: no bypass. A lookup of an index with a queued update returns the pre-update value.
- Updates to one index apply strictly in FIFO order.

Optional Feature:
- Macro: PHT_AGE_DRAIN_EN.
- Defined:
  - A head-age counter resets on each pop and on an empty queue, and increments each cycle the queue is non-empty in IDLE.
  - age_trip = (age >= AGE_LIMIT), forcing a drain even while lookup_req is held.
- Undefined: no age counter; age_trip=0. A continuously requesting IF starves updates until the queue is full.

Test Plan:
- Reset release with IDX_W=4:
  - busy=1 for exactly 16 cycles, writing wdata=01 to addresses 0..15 in order.
  - Then busy=0 and upd_ready=1.
- Lookup idx 5 after init: lookup_grant=1 in cycle T; lookup_valid=1 and lookup_taken=0 in T+1.
- Three taken updates to idx 5 with lookup_req low:
  - Writes of 10, 11, 11 appear, each after a read of idx 5 one cycle earlier.
  - A subsequent lookup returns taken=1.
- lookup_req held high, four updates pushed:
  - No drain until count=4; then upd_ready=0 and lookup_grant=0 for two cycles while the head drains.
  - With PHT_AGE_DRAIN_EN and AGE_LIMIT=8, the first drain starts after 8 waiting cycles instead.
- Not-taken update on a counter at 00 writes 00; taken update on a counter at 11 writes 11 (saturation).
- Assert RESET during UPD_WR with two queued entries:
  - Queue empties; no write occurs from the aborted update.
  - INIT restarts at address 0; lookup_valid=0.

Source files
------------

// File: rtl/pht_port_arbiter.sv
// pht_port_arbiter
// Owns the single-ported pattern history table (PHT) of saturating counters
// and shares its port between IF-stage prediction lookups (priority) and
// ID-stage resolved-branch updates (queued, applied as read-modify-write).
// After reset the whole table is written to weakly-not-taken before any
// traffic is accepted.
//
// Optional feature: define PHT_AGE_DRAIN_EN to add a head-age counter that
// forces an update drain after AGE_LIMIT waiting cycles even while IF keeps
// requesting. Without it a continuously requesting IF starves updates until
// the queue fills.
//
// Ports:
//   CLK, RESET            clock, asynchronous active-low reset
//   lookup_req/idx        IF prediction request and index
//   lookup_grant          lookup accepted this cycle (combinational)
//   lookup_valid/taken    result one cycle after grant (taken = counter MSB)
//   upd_valid/idx/taken   ID resolved branch
//   upd_ready             update queue can accept
//   busy                  table initialisation in progress
//   pht_en/we/addr/wdata  PHT port
//   pht_rdata             PHT read data, valid the cycle after a read
//
// state  | meaning
// INIT   | writing weakly-not-taken to every entry, one per cycle
// IDLE   | port free: drain queue head (read) or serve a lookup
// UPD_WR | write back the saturated head counter and pop it

module pht_port_arbiter #(
    parameter int IDX_W     = 10,
    parameter int CTR_W     = 2,
    parameter int QDEPTH    = 4,
    parameter int AGE_LIMIT = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             lookup_req,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_grant,
    output logic             lookup_valid,
    output logic             lookup_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic             busy,
    output logic             pht_en,
    output logic             pht_we,
    output logic [IDX_W-1:0] pht_addr,
    output logic [CTR_W-1:0] pht_wdata,
    input  logic [CTR_W-1:0] pht_rdata
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] Q_FULL  = CNT_W'(QDEPTH);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(1);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        UPD_WR = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   init_ptr;
    logic [IDX_W-1:0]   q_idx [QDEPTH];
    logic [QDEPTH-1:0]  q_taken;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic               push;
    logic               pop;
    logic               age_trip;
    logic               drain_now;
    logic [IDX_W-1:0]   head_idx;
    logic               head_taken;
    logic [CTR_W-1:0]   ctr_new;

    assign head_idx   = q_idx[head];
    assign head_taken = q_taken[head];
    assign push       = upd_valid && upd_ready;
    assign pop        = (state == UPD_WR);

`ifdef PHT_AGE_DRAIN_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);
    logic [AGE_W-1:0] age;

    // Age of the current head: cleared by a pop or an empty queue, counts
    // only while the head sits waiting in IDLE, saturates at the limit.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            age <= '0;
        end else if (pop || count == '0) begin
            age <= '0;
        end else if (state == IDLE && age < AGE_W'(AGE_LIMIT)) begin
            age <= age + AGE_W'(1);
        end
    end

    assign age_trip = (age >= AGE_W'(AGE_LIMIT));
`else
    // Age draining compiled out; this is constant false.
    assign age_trip = (AGE_LIMIT < 0);
`endif

    assign drain_now = (count != '0) && (!lookup_req || count == Q_FULL || age_trip);

    // Saturating counter update of the value read in the previous cycle.
    always_comb begin
        ctr_new = pht_rdata;
        if (head_taken) begin
            if (pht_rdata != CTR_MAX) ctr_new = pht_rdata + CTR_W'(1);
        end else begin
            if (pht_rdata != '0) ctr_new = pht_rdata - CTR_W'(1);
        end
    end

    always_comb begin
        lookup_grant = 1'b0;
        busy         = 1'b0;
        upd_ready    = 1'b0;
        pht_en       = 1'b0;
        pht_we       = 1'b0;
        pht_addr     = '0;
        pht_wdata    = '0;
        case (state)
            INIT: begin
                busy      = 1'b1;
                pht_en    = 1'b1;
                pht_we    = 1'b1;
                pht_addr  = init_ptr;
                pht_wdata = CTR_WNT;
            end
            IDLE: begin
                upd_ready = (count != Q_FULL);
                if (drain_now) begin
                    pht_en   = 1'b1;
                    pht_addr = head_idx;
                end else if (lookup_req) begin
                    lookup_grant = 1'b1;
                    pht_en       = 1'b1;
                    pht_addr     = lookup_idx;
                end
            end
            UPD_WR: begin
                upd_ready = (count != Q_FULL);
                pht_en    = 1'b1;
                pht_we    = 1'b1;
                pht_addr  = head_idx;
                pht_wdata = ctr_new;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= INIT;
            init_ptr     <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            lookup_valid <= 1'b0;
        end else begin
            lookup_valid <= lookup_grant;
            case (state)
                INIT: begin
                    init_ptr <= init_ptr + IDX_W'(1);
                    if (init_ptr == '1) state <= IDLE;
                end
                IDLE: begin
                    if (drain_now) state <= UPD_WR;
                end
                UPD_WR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= INIT;
                end
            endcase
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage needs no reset; validity is carried by head/tail/count.
    always_ff @(posedge CLK) begin
        if (push) begin
            q_idx[tail]   <= upd_idx;
            q_taken[tail] <= upd_taken;
        end
    end

    assign lookup_taken = lookup_valid & pht_rdata[CTR_W-1];

endmodule
